// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequential +4 fetch, redirect with epoch tagging,
// hazard stall hold, flush gating, misaligned-target halt and statistics counters.
module fetch_pc_gen #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2i_stall,
  input  logic                  i2i_flush,
  input  logic                  load_pc_we,
  input  logic [ADDR_WIDTH-1:0] load_pc_new_pc,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_valid,
  output logic [1:0]            fetch_epoch,
  output logic                  misalign_err,
  output logic [CNT_WIDTH-1:0]  redirect_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [1:0]            epoch_nxt;
  logic                  err_nxt;
  logic                  redirect_inc;
  logic                  stall_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BOOT;
      fetch_pc     <= RESET_PC;
      fetch_epoch  <= 2'd0;
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= pc_nxt;
      fetch_epoch  <= epoch_nxt;
      misalign_err <= err_nxt;
      if (redirect_inc && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + CNT_WIDTH'(1);
      if (stall_inc && (stall_cnt != '1))       stall_cnt    <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  // Redirect outranks stall; a misaligned redirect target is fatal until reset.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = fetch_pc;
    epoch_nxt    = fetch_epoch;
    err_nxt      = misalign_err;
    redirect_inc = 1'b0;
    stall_inc    = (state == STALL);
    case (state)
      BOOT: state_nxt = RUN;
      RUN, STALL: begin
        if (load_pc_we) begin
          if (load_pc_new_pc[1:0] != 2'b00) begin
            err_nxt   = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt       = load_pc_new_pc;
            epoch_nxt    = fetch_epoch + 2'd1;
            redirect_inc = 1'b1;
            state_nxt    = RUN;
          end
        end else if (i2i_stall) begin
          state_nxt = STALL;
        end else begin
          pc_nxt    = fetch_pc + ADDR_WIDTH'(4);
          state_nxt = RUN;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  // fetch_valid qualifies fetch_pc/fetch_epoch as a request in the current cycle;
  // there is no ready back-pressure, the consumer stalls via i2i_stall instead.
  assign fetch_valid = ((state == RUN) || (state == STALL)) && !i2i_flush;
  assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen; narrow counters so saturation is reachable.
module tb_fetch_pc_gen;

  localparam int AW = 32;
  localparam int CW = 4;
  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_HALT = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i2i_stall, i2i_flush, load_pc_we;
  logic [AW-1:0] load_pc_new_pc;
  logic [AW-1:0] fetch_pc;
  logic          fetch_valid;
  logic [1:0]    fetch_epoch;
  logic          misalign_err;
  logic [CW-1:0] redirect_cnt, stall_cnt;
  logic [1:0]    dbg_state;

  int vectors = 0;
  int miscompares = 0;

  fetch_pc_gen #(.ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i2i_stall(i2i_stall), .i2i_flush(i2i_flush),
    .load_pc_we(load_pc_we), .load_pc_new_pc(load_pc_new_pc),
    .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .fetch_epoch(fetch_epoch),
    .misalign_err(misalign_err), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    i2i_stall = 1'b0; i2i_flush = 1'b0; load_pc_we = 1'b0; load_pc_new_pc = '0;
  endtask

  // Leaves the DUT in its first RUN cycle with fetch_pc = 0.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i2i_stall = 1'b1; load_pc_we = 1'b1; load_pc_new_pc = 32'h400; i2i_flush = 1'b0;
    tick(); tick();
    vectors++; if (fetch_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h exp %h", fetch_pc, 32'h0); end
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
    vectors++; if (fetch_epoch !== 2'd0) begin miscompares++; $display("FAIL reset_epoch got %0d exp 0", fetch_epoch); end
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", misalign_err); end
    vectors++; if (redirect_cnt !== 4'd0 || stall_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", redirect_cnt, stall_cnt); end
    vectors++; if (dbg_state !== S_BOOT) begin miscompares++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_BOOT); end
  endtask

  task automatic test_boot_run();
    logic [AW-1:0] exp_pc [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    idle_inputs();
    rst_n = 1'b0; tick(); tick();
    // first cycle out of reset, with a redirect that BOOT must ignore
    rst_n = 1'b1; load_pc_we = 1'b1; load_pc_new_pc = 32'h100;
    #1;
    vectors++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h0) begin miscompares++; $display("FAIL boot_cycle got v=%b pc=%h exp v=0 pc=0", fetch_valid, fetch_pc); end
    tick();
    load_pc_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== exp_pc[i]) begin miscompares++; $display("FAIL run_seq%0d got v=%b pc=%h exp v=1 pc=%h", i, fetch_valid, fetch_pc, exp_pc[i]); end
      tick();
    end
    vectors++; if (fetch_epoch !== 2'd0 || redirect_cnt !== 4'd0) begin miscompares++; $display("FAIL boot_redirect_ignored got ep=%0d cnt=%0d exp 0/0", fetch_epoch, redirect_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    vectors++; if (fetch_pc !== 32'h10) begin miscompares++; $display("FAIL stall_setup got %h exp %h", fetch_pc, 32'h10); end
    i2i_stall = 1'b1;
    tick(); tick(); tick();
    vectors++; if (fetch_pc !== 32'h10 || dbg_state !== S_STALL || fetch_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold got pc=%h st=%0d v=%b exp pc=10 st=2 v=1", fetch_pc, dbg_state, fetch_valid); end
    vectors++; if (stall_cnt !== 4'd2) begin miscompares++; $display("FAIL stall_cnt_mid got %0d exp 2", stall_cnt); end
    i2i_stall = 1'b0;
    tick();
    vectors++; if (fetch_pc !== 32'h14 || dbg_state !== S_RUN) begin miscompares++; $display("FAIL stall_resume got pc=%h st=%0d exp pc=14 st=1", fetch_pc, dbg_state); end
    vectors++; if (stall_cnt !== 4'd3) begin miscompares++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
    tick();
    vectors++; if (fetch_pc !== 32'h18 || stall_cnt !== 4'd3) begin miscompares++; $display("FAIL stall_after got pc=%h cnt=%0d exp pc=18 cnt=3", fetch_pc, stall_cnt); end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    i2i_stall = 1'b1; load_pc_we = 1'b1; load_pc_new_pc = 32'h400;
    tick();
    vectors++; if (fetch_pc !== 32'h400 || fetch_epoch !== 2'd1) begin miscompares++; $display("FAIL redir_run got pc=%h ep=%0d exp pc=400 ep=1", fetch_pc, fetch_epoch); end
    vectors++; if (redirect_cnt !== 4'd1 || dbg_state !== S_RUN) begin miscompares++; $display("FAIL redir_run_cnt got cnt=%0d st=%0d exp cnt=1 st=1", redirect_cnt, dbg_state); end
    load_pc_we = 1'b0;
    tick();
    load_pc_we = 1'b1; load_pc_new_pc = 32'h800;
    tick();
    vectors++; if (fetch_pc !== 32'h800 || fetch_epoch !== 2'd2 || dbg_state !== S_RUN) begin miscompares++; $display("FAIL redir_stall got pc=%h ep=%0d st=%0d exp pc=800 ep=2 st=1", fetch_pc, fetch_epoch, dbg_state); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ep [4];
    exp_ep[0] = 2'd1; exp_ep[1] = 2'd2; exp_ep[2] = 2'd3; exp_ep[3] = 2'd0;
    do_reset();
    load_pc_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_pc_new_pc = 32'h100 * (i + 1);
      tick();
      vectors++; if (fetch_epoch !== exp_ep[i] || fetch_pc !== 32'h100 * (i + 1)) begin miscompares++; $display("FAIL b2b%0d got ep=%0d pc=%h exp ep=%0d pc=%h", i, fetch_epoch, fetch_pc, exp_ep[i], 32'h100 * (i + 1)); end
    end
    vectors++; if (redirect_cnt !== 4'd4) begin miscompares++; $display("FAIL b2b_cnt got %0d exp 4", redirect_cnt); end
    idle_inputs();
  endtask

  task automatic test_misalign();
    do_reset();
    tick(); tick();
    load_pc_we = 1'b1; load_pc_new_pc = 32'h402;
    tick();
    #1;
    vectors++; if (misalign_err !== 1'b1 || fetch_valid !== 1'b0 || fetch_pc !== 32'h8) begin miscompares++; $display("FAIL misalign got err=%b v=%b pc=%h exp err=1 v=0 pc=8", misalign_err, fetch_valid, fetch_pc); end
    vectors++; if (dbg_state !== S_HALT || redirect_cnt !== 4'd0) begin miscompares++; $display("FAIL misalign_state got st=%0d cnt=%0d exp st=3 cnt=0", dbg_state, redirect_cnt); end
    load_pc_new_pc = 32'h500; i2i_stall = 1'b1;
    tick(); tick();
    vectors++; if (fetch_pc !== 32'h8 || fetch_epoch !== 2'd0 || redirect_cnt !== 4'd0 || dbg_state !== S_HALT) begin miscompares++; $display("FAIL halt_frozen got pc=%h ep=%0d cnt=%0d st=%0d exp pc=8 ep=0 cnt=0 st=3", fetch_pc, fetch_epoch, redirect_cnt, dbg_state); end
    vectors++; if (stall_cnt !== 4'd0) begin miscompares++; $display("FAIL halt_stall_cnt got %0d exp 0", stall_cnt); end
    rst_n = 1'b0;
    tick();
    vectors++; if (misalign_err !== 1'b0 || fetch_pc !== 32'h0 || dbg_state !== S_BOOT) begin miscompares++; $display("FAIL halt_reset got err=%b pc=%h st=%0d exp err=0 pc=0 st=0", misalign_err, fetch_pc, dbg_state); end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_flush_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    i2i_flush = 1'b1;
    #1;
    vectors++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h20) begin miscompares++; $display("FAIL flush got v=%b pc=%h exp v=0 pc=20", fetch_valid, fetch_pc); end
    tick();
    i2i_flush = 1'b0;
    #1;
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h24) begin miscompares++; $display("FAIL flush_next got v=%b pc=%h exp v=1 pc=24", fetch_valid, fetch_pc); end
    load_pc_we = 1'b1; load_pc_new_pc = 32'hFFFF_FFF8;
    tick();
    load_pc_we = 1'b0;
    tick();
    vectors++; if (fetch_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pre got %h exp fffffffc", fetch_pc); end
    tick();
    vectors++; if (fetch_pc !== 32'h0 || misalign_err !== 1'b0 || fetch_valid !== 1'b1 || dbg_state !== S_RUN) begin miscompares++; $display("FAIL wrap got pc=%h err=%b v=%b st=%0d exp pc=0 err=0 v=1 st=1", fetch_pc, misalign_err, fetch_valid, dbg_state); end
  endtask

  task automatic test_saturate_and_reset_mid();
    do_reset();
    i2i_stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    vectors++; if (stall_cnt !== 4'hF || fetch_pc !== 32'h0) begin miscompares++; $display("FAIL stall_sat got cnt=%0d pc=%h exp cnt=15 pc=0", stall_cnt, fetch_pc); end
    load_pc_we = 1'b1;
    for (int i = 0; i < 17; i++) begin
      load_pc_new_pc = 32'h40 + 32'(i) * 4;
      tick();
    end
    vectors++; if (redirect_cnt !== 4'hF || fetch_pc !== 32'h80) begin miscompares++; $display("FAIL redir_sat got cnt=%0d pc=%h exp cnt=15 pc=80", redirect_cnt, fetch_pc); end
    load_pc_we = 1'b0;
    tick();
    rst_n = 1'b0; load_pc_we = 1'b1; load_pc_new_pc = 32'h900;
    tick();
    vectors++; if (dbg_state !== S_BOOT || fetch_pc !== 32'h0 || stall_cnt !== 4'd0 || redirect_cnt !== 4'd0 || fetch_epoch !== 2'd0) begin miscompares++; $display("FAIL reset_mid got st=%0d pc=%h sc=%0d rc=%0d ep=%0d exp all 0", dbg_state, fetch_pc, stall_cnt, redirect_cnt, fetch_epoch); end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_boot_run();
    test_stall();
    test_redirect_priority();
    test_back_to_back();
    test_misalign();
    test_flush_wrap();
    test_saturate_and_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, PC width; RESET_PC, default 32'h0000_0000, first fetch address; CNT_WIDTH, default 32, statistics counter width.
REQ-002 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: i2i_stall  in  1  hold PC (from hazard control).
REQ-005 SHALL have ports: i2i_flush  in  1  invalidate current fetch slot.
REQ-006 SHALL have ports: load_pc_we  in  1  redirect request.
REQ-007 SHALL have ports: load_pc_new_pc  in  ADDR_WIDTH  redirect target.
REQ-008 SHALL have ports: fetch_pc  out  ADDR_WIDTH  address presented to I-cache.
REQ-009 SHALL have ports: fetch_valid  out  1  fetch_pc is a live request.
REQ-010 SHALL have ports: fetch_epoch  out  2  redirect epoch tag travelling with the fetch.
REQ-011 SHALL have ports: misalign_err  out  1  sticky misaligned-target error.
REQ-012 SHALL have ports: redirect_cnt  out  CNT_WIDTH  accepted redirects.
REQ-013 SHALL have ports: stall_cnt  out  CNT_WIDTH  cycles spent in STALL.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, STALL, HALT; state register updates only on posedge clk.
REQ-015 BOOT: entered on reset; fetch_valid=0; unconditionally -> RUN next cycle, fetch_pc held at RESET_PC.
REQ-016 RUN: fetch_valid=1; with no redirect and i2i_stall=0, fetch_pc <= fetch_pc + 4 (modulo 2^ADDR_WIDTH, wrap from all-ones-minus-3 to 0 without error).
REQ-017 RUN with i2i_stall=1 and no redirect: fetch_pc held, -> STALL; STALL holds fetch_pc, fetch_valid=1, returns to RUN on first cycle i2i_stall=0 (PC then advances per REQ-016 in that cycle).
REQ-018 Redirect (load_pc_we=1, aligned target) in RUN or STALL SHALL take priority over i2i_stall: fetch_pc <= load_pc_new_pc, fetch_epoch <= fetch_epoch+1 (2-bit wrap 3->0), redirect_cnt +1, next state RUN.
REQ-019 Redirect in BOOT SHALL be ignored (not counted, no epoch change).
REQ-020 Misaligned target (load_pc_new_pc[1:0]!=0) with load_pc_we=1 in RUN/STALL: fetch_pc unchanged, misalign_err <= 1, -> HALT, redirect_cnt unchanged.
REQ-021 HALT: fetch_valid=0, fetch_pc frozen, all inputs ignored; exit only by reset.
REQ-022 fetch_valid SHALL be combinationally forced 0 in any cycle with i2i_flush=1 (state and PC update unaffected by flush).
REQ-023 stall_cnt SHALL increment once per cycle while state==STALL; both counters saturate at all-ones.
REQ-024 Outputs fetch_pc, fetch_epoch, misalign_err, counters SHALL be registered; fetch_valid is state-decoded plus REQ-022 gating.
REQ-025 Single-cycle latency: redirect in cycle N is visible on fetch_pc in cycle N+1.

Reset
REQ-026 While rst_n=0 at a clock edge: state<=BOOT, fetch_pc<=RESET_PC, fetch_epoch<=0, misalign_err<=0, redirect_cnt<=0, stall_cnt<=0; fetch_valid=0.
REQ-027 Reset asserted mid-STALL, mid-redirect or in HALT SHALL override every other input in that cycle.

Verification
REQ-028 Reset release, no stalls, 4 cycles -> cycle1 fetch_valid=0 pc=0; then pc 0,4,8 with fetch_valid=1.
REQ-029 i2i_stall=1 for 3 cycles at pc=0x10 -> pc stays 0x10, stall_cnt=3, resumes 0x14 after release.
REQ-030 load_pc_we=1 target 0x400 together with i2i_stall=1 -> next pc=0x400, epoch 0->1, redirect_cnt=1, state RUN.
REQ-031 Four back-to-back redirects -> epoch sequence 1,2,3,0; redirect_cnt=4.
REQ-032 Redirect target 0x402 -> misalign_err=1, fetch_valid=0, pc unchanged; further redirects ignored until reset clears all.
REQ-033 i2i_flush=1 in RUN at pc=0x20 -> fetch_valid=0 that cycle, pc=0x24 next cycle; pc=0xFFFF_FFFC advancing -> 0x0, no error.
